// File: rtl/text_char_fetch.sv
// -----------------------------------------------------------------------------
// text_char_fetch
//   Text-mode scan-out sequencer. For every visible scanline it walks one row
//   of the text buffer, forms a charset ROM address {code, glyph_row} for each
//   character and shifts the returned glyph byte out MSB-first as a 1-bit
//   pixel stream, one pixel per clock.
//
//   Pipeline (line_start sampled in cycle L):
//     L+1 tram_addr valid, L+2 tram_data, L+3 cs_addr valid, L+4 cs_q,
//     L+5 first pixel. The next column's text fetch is issued so that its
//     glyph byte lands exactly at the pixel 7 -> pixel 0 boundary.
//
// Parameters
//   COLS    characters per text row (1..255)
//   ROWS    text rows per frame (1..63)
//   TRAM_AW text RAM address width, COLS*ROWS <= 2**TRAM_AW
//
// Ports
//   clk          system clock, one pixel per cycle
//   rst_n        synchronous active-low reset
//   frame_start  one-cycle pulse at top of frame (clears line counters)
//   line_start   one-cycle pulse at start of each visible scanline
//   tram_addr    text RAM read address (registered)
//   tram_data    character code, valid the cycle after tram_addr
//   cs_addr      charset ROM address {code, glyph_row} (registered)
//   cs_q         glyph row byte, valid the cycle after cs_addr
//   pix_on       pixel foreground bit (0 whenever pix_valid is 0)
//   pix_valid    high while pix_on carries a character pixel
//   busy         high from line fetch start until the last pixel of the line
//
// Optional feature (macro TEXT_CURSOR_EN)
//   cursor_addr  in  text-buffer index of the cursor cell
//   cursor_blink out bit 5 of a frame counter (64-frame period)
//   The cursor cell's glyph rows 14/15 are inverted while cursor_blink is 1.
// -----------------------------------------------------------------------------
module text_char_fetch #(
    parameter int unsigned COLS    = 80,
    parameter int unsigned ROWS    = 30,
    parameter int unsigned TRAM_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               line_start,
    output logic [TRAM_AW-1:0] tram_addr,
    input  logic [7:0]         tram_data,
    output logic [11:0]        cs_addr,
    input  logic [7:0]         cs_q,
    output logic               pix_on,
    output logic               pix_valid,
    output logic               busy
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [TRAM_AW-1:0] cursor_addr,
    output logic               cursor_blink
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT
    } state_e;

    // One extra bit on row_base so the end-of-frame value never aliases to 0.
    localparam logic [TRAM_AW:0] CELLS    = (TRAM_AW+1)'(ROWS * COLS);
    localparam logic [TRAM_AW:0] COLS_W   = (TRAM_AW+1)'(COLS);
    localparam logic [7:0]       LAST_COL = 8'(COLS - 1);

    state_e             state_q, state_d;
    logic [TRAM_AW-1:0] tram_addr_q, tram_addr_d;
    logic [11:0]        cs_addr_q, cs_addr_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         col_q, col_d;
    logic [3:0]         pipe_q, pipe_d;       // bit i: text fetch issued i cycles ago
    logic [3:0]         glyph_row_q, glyph_row_d;
    logic [TRAM_AW:0]   row_base_q, row_base_d;
    logic [7:0]         load_byte;

`ifdef TEXT_CURSOR_EN
    logic [5:0]         frame_cnt_q, frame_cnt_d;
    logic [2:0]         cur_q, cur_d;         // cursor-hit flag travelling with pipe_q
    logic               cursor_hit;

    assign cursor_hit = (tram_addr_q == cursor_addr) &&
                        (glyph_row_q[3:1] == 3'b111) &&
                        frame_cnt_q[5];
    assign load_byte  = cs_q ^ {8{cur_q[2]}};
    assign cursor_blink = frame_cnt_q[5];
`else
    assign load_byte  = cs_q;
`endif

    always_comb begin
        state_d     = state_q;
        tram_addr_d = tram_addr_q;
        cs_addr_d   = cs_addr_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        col_d       = col_q;
        pipe_d      = {pipe_q[2:0], 1'b0};
        glyph_row_d = glyph_row_q;
        row_base_d  = row_base_q;
`ifdef TEXT_CURSOR_EN
        frame_cnt_d = frame_cnt_q;
        cur_d       = {cur_q[1:0], pipe_q[0] & cursor_hit};
`endif

        // Text RAM data for the fetch issued last cycle is present now.
        if (pipe_q[1]) begin
            cs_addr_d = {tram_data, glyph_row_q};
        end

        unique case (state_q)
            S_IDLE: ;
            S_FETCH: begin
                if (pipe_q[3]) begin
                    shift_d = load_byte;
                    bit_d   = '0;
                    col_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[6:0], 1'b0};
                bit_d   = bit_q + 3'd1;
                // Issuing at the end of pixel 3 puts the address on the bus
                // during pixel 4, so the byte arrives for the pixel 7 -> 0 load.
                if (bit_q == 3'd3 && col_q != LAST_COL) begin
                    tram_addr_d = TRAM_AW'(row_base_q + (TRAM_AW+1)'(col_q) + 1'b1);
                    pipe_d[0]   = 1'b1;
                end
                if (bit_q == 3'd7) begin
                    if (col_q == LAST_COL) begin
                        state_d     = S_IDLE;
                        glyph_row_d = glyph_row_q + 4'd1;
                        if (glyph_row_q == 4'd15 && row_base_q < CELLS) begin
                            row_base_d = row_base_q + COLS_W;
                        end
                    end else begin
                        shift_d = load_byte;
                        col_d   = col_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_start) begin
            glyph_row_d = '0;
            row_base_d  = '0;
            state_d     = S_IDLE;
            pipe_d      = '0;
`ifdef TEXT_CURSOR_EN
            frame_cnt_d = frame_cnt_q + 6'd1;
`endif
        end

        // An aborting line_start must not let a coincident line completion
        // advance the counters; a coincident frame_start has already cleared them.
        if (line_start && !frame_start) begin
            glyph_row_d = glyph_row_q;
            row_base_d  = row_base_q;
        end

        if (line_start && (frame_start || row_base_q < CELLS)) begin
            state_d     = S_FETCH;
            tram_addr_d = frame_start ? '0 : TRAM_AW'(row_base_q);
            pipe_d      = 4'b0001;
            shift_d     = '0;
`ifdef TEXT_CURSOR_EN
            cur_d       = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tram_addr_q <= '0;
            cs_addr_q   <= '0;
            shift_q     <= '0;
            bit_q       <= '0;
            col_q       <= '0;
            pipe_q      <= '0;
            glyph_row_q <= '0;
            row_base_q  <= '0;
`ifdef TEXT_CURSOR_EN
            frame_cnt_q <= '0;
            cur_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tram_addr_q <= tram_addr_d;
            cs_addr_q   <= cs_addr_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            col_q       <= col_d;
            pipe_q      <= pipe_d;
            glyph_row_q <= glyph_row_d;
            row_base_q  <= row_base_d;
`ifdef TEXT_CURSOR_EN
            frame_cnt_q <= frame_cnt_d;
            cur_q       <= cur_d;
`endif
        end
    end

    assign tram_addr = tram_addr_q;
    assign cs_addr   = cs_addr_q;
    assign pix_valid = (state_q == S_SHIFT);
    assign pix_on    = pix_valid & shift_q[7];
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_text_char_fetch.sv
// -----------------------------------------------------------------------------
// tb_text_char_fetch
//   Directed bench for text_char_fetch. Two instances share clock and control:
//   dut (COLS=2, ROWS=2) and dut1 (COLS=2, ROWS=1), each with its own
//   one-cycle-latency text RAM and charset ROM stubs. Cycle j of a line means
//   j cycles after the cycle in which line_start was sampled.
// -----------------------------------------------------------------------------
module tb_text_char_fetch;

    logic       clk = 1'b0;
    logic       rst_n, frame_start, line_start;
    logic [3:0] tram_addr, tram_addr1;
    logic [7:0] tram_data, tram_data1;
    logic [11:0] cs_addr, cs_addr1;
    logic [7:0] cs_q, cs_q1;
    logic       pix_on, pix_valid, busy;
    logic       pix_on1, pix_valid1, busy1;
`ifdef TEXT_CURSOR_EN
    logic [3:0] cursor_addr;
    logic       cursor_blink, cursor_blink1;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] tmem [16];

    logic [20:0] obs_valid, obs_busy, obs_on, obs_valid1, obs_busy1;
    logic [3:0]  obs_t1, obs_t9;
    logic [11:0] obs_cs3;

    always #5 clk = ~clk;

    text_char_fetch #(.COLS(2), .ROWS(2), .TRAM_AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
        .tram_addr(tram_addr), .tram_data(tram_data), .cs_addr(cs_addr), .cs_q(cs_q),
        .pix_on(pix_on), .pix_valid(pix_valid), .busy(busy)
`ifdef TEXT_CURSOR_EN
        , .cursor_addr(cursor_addr), .cursor_blink(cursor_blink)
`endif
    );

    text_char_fetch #(.COLS(2), .ROWS(1), .TRAM_AW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
        .tram_addr(tram_addr1), .tram_data(tram_data1), .cs_addr(cs_addr1), .cs_q(cs_q1),
        .pix_on(pix_on1), .pix_valid(pix_valid1), .busy(busy1)
`ifdef TEXT_CURSOR_EN
        , .cursor_addr(cursor_addr), .cursor_blink(cursor_blink1)
`endif
    );

    // Charset ROM contents used by the bench (row-independent glyphs).
    function automatic logic [7:0] rom(input logic [11:0] a);
        case (a[11:4])
            8'h41:   rom = 8'hA5;
            8'h42:   rom = 8'h3C;
            8'h43:   rom = 8'hF0;
            8'h44:   rom = 8'h81;
            default: rom = 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        tram_data  <= tmem[tram_addr];
        cs_q       <= rom(cs_addr);
        tram_data1 <= tmem[tram_addr1];
        cs_q1      <= rom(cs_addr1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse line_start for one cycle; returns in cycle j=1 of the line.
    task automatic pulse_line();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    // Records cycles j=1..21 (MSB = j1) and returns in cycle j=22.
    task automatic capture_line();
        obs_valid = '0; obs_busy = '0; obs_on = '0; obs_valid1 = '0; obs_busy1 = '0;
        for (int j = 1; j <= 21; j++) begin
            obs_valid  = {obs_valid[19:0],  pix_valid};
            obs_busy   = {obs_busy[19:0],   busy};
            obs_on     = {obs_on[19:0],     pix_on};
            obs_valid1 = {obs_valid1[19:0], pix_valid1};
            obs_busy1  = {obs_busy1[19:0],  busy1};
            if (j == 1) obs_t1  = tram_addr;
            if (j == 3) obs_cs3 = cs_addr;
            if (j == 9) obs_t9  = tram_addr;
            tick();
        end
    endtask

    // Full-line checks for dut: 16 valid pixels in j5..j20, busy j1..j20.
    task automatic check_line(input string tag, input logic [15:0] pix,
                              input logic [3:0] t1, input logic [11:0] cs3);
        check({tag, ".valid"}, 32'(obs_valid), 32'h1FFFE);
        check({tag, ".busy"},  32'(obs_busy),  32'h1FFFFE);
        check({tag, ".pix"},   32'(obs_on),    32'({4'b0, pix, 1'b0}));
        check({tag, ".tram1"}, 32'(obs_t1),    32'(t1));
        check({tag, ".tram9"}, 32'(obs_t9),    32'(t1 + 4'd1));
        check({tag, ".cs3"},   32'(obs_cs3),   32'(cs3));
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; line_start = 1'b0;
`ifdef TEXT_CURSOR_EN
        cursor_addr = 4'd1;
`endif
        for (int i = 0; i < 16; i++) tmem[i] = 8'h00;
        tmem[0] = 8'h41; tmem[1] = 8'h42; tmem[2] = 8'h43; tmem[3] = 8'h44;

        // Reset held while line_start pulses: no activity at all.
        for (int i = 0; i < 3; i++) begin
            line_start = 1'b1;
            tick();
            check($sformatf("reset%0d", i),
                  32'({tram_addr, cs_addr, pix_on, pix_valid, busy}), 32'h0);
        end
        rst_n = 1'b1; line_start = 1'b0;
        tick(); tick();
        check("post_reset_idle", 32'({tram_addr, busy, pix_valid}), 32'h0);

        frame_start = 1'b1; tick(); frame_start = 1'b0;
        repeat (3) tick();

        // Line 0: codes 0x41/0x42 -> A5, 3C.
        pulse_line(); capture_line();
        check_line("line0", 16'hA53C, 4'd0, 12'h410);
        check("line0.dut1_valid", 32'(obs_valid1), 32'h1FFFE);

        // Lines 1..15: glyph_row steps through cs_addr low nibble.
        for (int i = 1; i < 16; i++) begin
            pulse_line(); capture_line();
            check($sformatf("line%0d.cs3", i), 32'(obs_cs3), 32'({8'h41, i[3:0]}));
            check($sformatf("line%0d.pix", i), 32'(obs_on), 32'({4'b0, 16'hA53C, 1'b0}));
        end

        // 17th line: row_base advanced to COLS; ROWS=1 instance ignores it.
        pulse_line(); capture_line();
        check_line("line16", 16'hF081, 4'd2, 12'h430);
        check("line16.dut1_busy",  32'(obs_busy1),  32'h0);
        check("line16.dut1_valid", 32'(obs_valid1), 32'h0);

        // Abort at pixel 3 of column 1 (j=16), restart with same counters.
        pulse_line();
        repeat (15) tick();
        check("abort.pre_valid", 32'(pix_valid), 32'h1);
        line_start = 1'b1; tick(); line_start = 1'b0;
        check("abort.valid_drop", 32'(pix_valid), 32'h0);
        check("abort.busy", 32'(busy), 32'h1);
        capture_line();
        check_line("abort.restart", 16'hF081, 4'd2, 12'h431);
        pulse_line(); capture_line();
        check("after_abort.cs3", 32'(obs_cs3), 32'h432);

        // frame_start and line_start together: line runs with cleared counters.
        frame_start = 1'b1; line_start = 1'b1; tick();
        frame_start = 1'b0; line_start = 1'b0;
        capture_line();
        check_line("frame_and_line", 16'hA53C, 4'd0, 12'h410);

        // frame_start mid-line aborts to idle and clears counters.
        pulse_line();
        repeat (7) tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("frame_abort", 32'({busy, pix_valid, pix_on}), 32'h0);
        pulse_line(); capture_line();
        check_line("after_frame_abort", 16'hA53C, 4'd0, 12'h410);

        // Reset mid-line.
        pulse_line();
        repeat (9) tick();
        rst_n = 1'b0; tick();
        check("reset_midline", 32'({tram_addr, cs_addr, pix_on, pix_valid, busy}), 32'h0);
        rst_n = 1'b1; tick();

`ifdef TEXT_CURSOR_EN
        // Blank cells, 32 frames -> blink on, cursor on cell 1.
        tmem[0] = 8'h00; tmem[1] = 8'h00;
        for (int i = 0; i < 32; i++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        end
        check("cursor.blink", 32'(cursor_blink), 32'h1);
        for (int r = 0; r < 13; r++) begin
            pulse_line(); capture_line();
        end
        pulse_line(); capture_line();
        check_line("cursor.row13", 16'h0000, 4'd0, 12'h00D);
        pulse_line(); capture_line();
        check_line("cursor.row14", 16'h00FF, 4'd0, 12'h00E);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
